// File: rtl/rs_add_sub.sv
// Add/sub reservation station: holds issued ops, snoops the CDB, dispatches to the FU.
// Optional macro RS_AGE_PRIORITY_EN selects the oldest ready entry instead of the lowest index.
module rs_add_sub #(
    parameter int DEPTH = 3,
    parameter int DW    = 9,
    parameter int TW    = 3
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       issue_valid,
    output logic                       issue_ready,
    input  logic [2:0]                 issue_op,
    input  logic [TW-1:0]              issue_addr,
    input  logic [TW-1:0]              issue_label,
    input  logic [DW-1:0]              issue_x,
    input  logic                       issue_x_pend,
    input  logic [TW-1:0]              issue_x_tag,
    input  logic [DW-1:0]              issue_y,
    input  logic                       issue_y_pend,
    input  logic [TW-1:0]              issue_y_tag,
    input  logic                       cdb_valid,
    input  logic [TW-1:0]              cdb_tag,
    input  logic [DW-1:0]              cdb_data,
    output logic                       fu_run,
    output logic [DW-1:0]              fu_regx,
    output logic [DW-1:0]              fu_regy,
    output logic [2:0]                 fu_opcode,
    output logic [TW-1:0]              fu_addr,
    output logic [TW-1:0]              fu_label,
    input  logic                       fu_done,
    output logic [$clog2(DEPTH+1)-1:0] busy_count
);

    localparam int CW = $clog2(DEPTH+1);
    localparam int IW = $clog2(DEPTH);

    typedef struct packed {
        logic          valid;
        logic [2:0]    op;
        logic [TW-1:0] addr;
        logic [TW-1:0] label;
        logic [DW-1:0] x;
        logic          xp;
        logic [TW-1:0] xt;
        logic [DW-1:0] y;
        logic          yp;
        logic [TW-1:0] yt;
    } ent_t;

    typedef enum logic {IDLE, EXEC} state_t;

    ent_t          ent_q [DEPTH];
    ent_t          ent_d [DEPTH];
    state_t        state_q;
    logic [CW-1:0] busy_q;
    logic [CW-1:0] busy_d;
    logic          sel_vld;
    logic [IW-1:0] sel;
    logic          free_vld;
    logic [IW-1:0] free;
    logic          disp;
    logic          iss;
`ifdef RS_AGE_PRIORITY_EN
    logic [IW-1:0] age_q [DEPTH];
    logic [IW-1:0] age_d [DEPTH];
    logic [IW-1:0] best_age;
`endif

    // Readiness is judged on registered state only; wakeups count from the next cycle.
    always_comb begin
        sel_vld = 1'b0;
        sel     = '0;
`ifdef RS_AGE_PRIORITY_EN
        best_age = '0;
`endif
        for (int i = 0; i < DEPTH; i++) begin
            if (ent_q[i].valid && !ent_q[i].xp && !ent_q[i].yp) begin
`ifdef RS_AGE_PRIORITY_EN
                if (!sel_vld || age_q[i] < best_age) begin
                    sel_vld  = 1'b1;
                    sel      = IW'(i);
                    best_age = age_q[i];
                end
`else
                if (!sel_vld) begin
                    sel_vld = 1'b1;
                    sel     = IW'(i);
                end
`endif
            end
        end
    end

    always_comb begin
        free_vld = 1'b0;
        free     = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (!ent_q[i].valid && !free_vld) begin
                free_vld = 1'b1;
                free     = IW'(i);
            end
        end
    end

    assign issue_ready = free_vld;
    assign disp        = (state_q == IDLE) && sel_vld;
    assign iss         = issue_valid && free_vld;
    assign busy_count  = busy_q;

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            ent_d[i] = ent_q[i];
            if (ent_q[i].valid && cdb_valid) begin
                if (ent_q[i].xp && ent_q[i].xt == cdb_tag) begin
                    ent_d[i].x  = cdb_data;
                    ent_d[i].xp = 1'b0;
                end
                if (ent_q[i].yp && ent_q[i].yt == cdb_tag) begin
                    ent_d[i].y  = cdb_data;
                    ent_d[i].yp = 1'b0;
                end
            end
        end
        if (disp) begin
            ent_d[sel].valid = 1'b0;
        end
        if (iss) begin
            ent_d[free].valid = 1'b1;
            ent_d[free].op    = issue_op;
            ent_d[free].addr  = issue_addr;
            ent_d[free].label = issue_label;
            ent_d[free].x     = issue_x;
            ent_d[free].xp    = issue_x_pend;
            ent_d[free].xt    = issue_x_tag;
            ent_d[free].y     = issue_y;
            ent_d[free].yp    = issue_y_pend;
            ent_d[free].yt    = issue_y_tag;
            // Same-cycle CDB broadcast is captured at issue so it is never missed.
            if (cdb_valid && issue_x_pend && issue_x_tag == cdb_tag) begin
                ent_d[free].x  = cdb_data;
                ent_d[free].xp = 1'b0;
            end
            if (cdb_valid && issue_y_pend && issue_y_tag == cdb_tag) begin
                ent_d[free].y  = cdb_data;
                ent_d[free].yp = 1'b0;
            end
        end
        busy_d = '0;
        for (int i = 0; i < DEPTH; i++) begin
            busy_d = busy_d + CW'(ent_d[i].valid);
        end
    end

`ifdef RS_AGE_PRIORITY_EN
    // Rank 0 is the oldest; leaving entries close the gap, new entries take the tail.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            age_d[i] = age_q[i];
            if (disp && ent_q[i].valid && age_q[i] > age_q[sel]) begin
                age_d[i] = age_q[i] - IW'(1);
            end
        end
        if (iss) begin
            age_d[free] = IW'(busy_q - CW'(disp));
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                age_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                age_q[i] <= age_d[i];
            end
        end
    end
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                ent_q[i] <= '0;
            end
            state_q   <= IDLE;
            busy_q    <= '0;
            fu_run    <= 1'b0;
            fu_regx   <= '0;
            fu_regy   <= '0;
            fu_opcode <= '0;
            fu_addr   <= '0;
            fu_label  <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                ent_q[i] <= ent_d[i];
            end
            busy_q <= busy_d;
            unique case (state_q)
                IDLE: begin
                    if (disp) begin
                        fu_regx   <= ent_q[sel].x;
                        fu_regy   <= ent_q[sel].y;
                        fu_opcode <= ent_q[sel].op;
                        fu_addr   <= ent_q[sel].addr;
                        fu_label  <= ent_q[sel].label;
                        fu_run    <= 1'b1;
                        state_q   <= EXEC;
                    end
                end
                EXEC: begin
                    if (fu_done) begin
                        fu_run  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rs_add_sub.sv
// Scoreboard bench for rs_add_sub: expected dispatches queued at issue, checked at the FU.
// Define RS_AGE_PRIORITY_EN for both files to exercise oldest-first selection.
module tb_rs_add_sub;

    logic       clk = 1'b0;
    logic       reset;
    logic       issue_valid;
    logic       issue_ready;
    logic [2:0] issue_op;
    logic [2:0] issue_addr;
    logic [2:0] issue_label;
    logic [8:0] issue_x;
    logic       issue_x_pend;
    logic [2:0] issue_x_tag;
    logic [8:0] issue_y;
    logic       issue_y_pend;
    logic [2:0] issue_y_tag;
    logic       cdb_valid;
    logic [2:0] cdb_tag;
    logic [8:0] cdb_data;
    logic       fu_run;
    logic [8:0] fu_regx;
    logic [8:0] fu_regy;
    logic [2:0] fu_opcode;
    logic [2:0] fu_addr;
    logic [2:0] fu_label;
    logic       fu_done;
    logic [1:0] busy_count;

    typedef struct {
        logic [2:0] op;
        logic [2:0] addr;
        logic [2:0] label;
        logic [8:0] x;
        logic [8:0] y;
    } exp_t;

    exp_t sbq[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    rs_add_sub #(.DEPTH(3), .DW(9), .TW(3)) dut (
        .clk(clk), .reset(reset),
        .issue_valid(issue_valid), .issue_ready(issue_ready),
        .issue_op(issue_op), .issue_addr(issue_addr), .issue_label(issue_label),
        .issue_x(issue_x), .issue_x_pend(issue_x_pend), .issue_x_tag(issue_x_tag),
        .issue_y(issue_y), .issue_y_pend(issue_y_pend), .issue_y_tag(issue_y_tag),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
        .fu_run(fu_run), .fu_regx(fu_regx), .fu_regy(fu_regy),
        .fu_opcode(fu_opcode), .fu_addr(fu_addr), .fu_label(fu_label),
        .fu_done(fu_done), .busy_count(busy_count)
    );

    function automatic exp_t mk(input logic [2:0] op, input logic [2:0] addr,
                                input logic [2:0] label, input logic [8:0] x,
                                input logic [8:0] y);
        exp_t e;
        e.op = op; e.addr = addr; e.label = label; e.x = x; e.y = y;
        return e;
    endfunction

    // Called at a negedge; drives one issue across the next posedge.
    task automatic do_issue(input logic [2:0] op, input logic [2:0] addr,
                            input logic [2:0] label,
                            input logic [8:0] x, input logic xp, input logic [2:0] xt,
                            input logic [8:0] y, input logic yp, input logic [2:0] yt);
        issue_valid = 1'b1; issue_op = op; issue_addr = addr; issue_label = label;
        issue_x = x; issue_x_pend = xp; issue_x_tag = xt;
        issue_y = y; issue_y_pend = yp; issue_y_tag = yt;
        @(negedge clk);
        issue_valid = 1'b0;
        cdb_valid = 1'b0;
    endtask

    task automatic do_cdb(input logic [2:0] tag, input logic [8:0] data);
        cdb_valid = 1'b1; cdb_tag = tag; cdb_data = data;
        @(negedge clk);
        cdb_valid = 1'b0;
    endtask

    // Scoreboard consumer: waits for a dispatch, pops and compares, then completes the op.
    task automatic wait_dispatch(input string name, input int budget);
        int   n = 0;
        exp_t e;
        while (fu_run !== 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (fu_run !== 1'b1) begin
            errors++;
            $display("FAIL %s: fu_run=%b, required 1 within %0d cycles", name, fu_run, budget);
            return;
        end
        checks++;
        if (sbq.size() == 0) begin
            errors++;
            $display("FAIL %s: dispatch observed, none expected", name);
            return;
        end
        e = sbq.pop_front();
        for (int c = 0; c < 3; c++) begin
            checks++;
            if ({fu_opcode, fu_addr, fu_label, fu_regx, fu_regy} !==
                {e.op, e.addr, e.label, e.x, e.y} || fu_run !== 1'b1) begin
                errors++;
                $display("FAIL %s cyc%0d: run=%b op=%0d addr=%0d lbl=%0d x=%0d y=%0d, required run=1 op=%0d addr=%0d lbl=%0d x=%0d y=%0d",
                         name, c, fu_run, fu_opcode, fu_addr, fu_label, fu_regx, fu_regy,
                         e.op, e.addr, e.label, e.x, e.y);
            end
            @(negedge clk);
        end
        fu_done = 1'b1;
        @(negedge clk);
        fu_done = 1'b0;
        checks++;
        if (fu_run !== 1'b0) begin
            errors++;
            $display("FAIL %s_done: fu_run=%b, required 0", name, fu_run);
        end
    endtask

    task automatic test_reset;
        checks++;
        if ({fu_run, busy_count, issue_ready, fu_regx, fu_regy, fu_opcode, fu_addr, fu_label}
            !== {1'b0, 2'd0, 1'b1, 9'd0, 9'd0, 3'd0, 3'd0, 3'd0}) begin
            errors++;
            $display("FAIL reset: run=%b busy=%0d rdy=%b x=%0d y=%0d op=%0d, required 0 0 1 0 0 0",
                     fu_run, busy_count, issue_ready, fu_regx, fu_regy, fu_opcode);
        end
    endtask

    task automatic test_basic_add;
        sbq.push_back(mk(3'b000, 3'd1, 3'd2, 9'd5, 9'd3));
        do_issue(3'b000, 3'd1, 3'd2, 9'd5, 1'b0, 3'd0, 9'd3, 1'b0, 3'd0);
        checks++;
        if (fu_run !== 1'b0 || busy_count !== 2'd1) begin
            errors++;
            $display("FAIL t1_latency: run=%b busy=%0d, required 0 1", fu_run, busy_count);
        end
        wait_dispatch("t1_add", 1);
    endtask

    task automatic test_wakeup;
        sbq.push_back(mk(3'b001, 3'd2, 3'd3, 9'd20, 9'd7));
        do_issue(3'b001, 3'd2, 3'd3, 9'd0, 1'b1, 3'd4, 9'd7, 1'b0, 3'd0);
        for (int i = 0; i < 3; i++) begin
            fu_done = (i == 1);
            checks++;
            if (fu_run !== 1'b0 || busy_count !== 2'd1) begin
                errors++;
                $display("FAIL t2_wait%0d: run=%b busy=%0d, required 0 1", i, fu_run, busy_count);
            end
            @(negedge clk);
        end
        fu_done = 1'b0;
        do_cdb(3'd4, 9'd20);
        checks++;
        if (fu_run !== 1'b0) begin
            errors++;
            $display("FAIL t2_wake_edge: run=%b, required 0", fu_run);
        end
        wait_dispatch("t2_sub", 1);
    endtask

    task automatic test_bypass;
        sbq.push_back(mk(3'b000, 3'd6, 3'd5, 9'd9, 9'd2));
        cdb_valid = 1'b1; cdb_tag = 3'd1; cdb_data = 9'd9;
        do_issue(3'b000, 3'd6, 3'd5, 9'd0, 1'b1, 3'd1, 9'd2, 1'b0, 3'd0);
        wait_dispatch("t3_bypass", 1);
    endtask

    task automatic test_full;
        sbq.push_back(mk(3'b000, 3'd1, 3'd1, 9'd11, 9'd1));
        sbq.push_back(mk(3'b001, 3'd2, 3'd2, 9'd11, 9'd2));
        sbq.push_back(mk(3'b101, 3'd3, 3'd3, 9'd11, 9'd3));
        do_issue(3'b000, 3'd1, 3'd1, 9'd0, 1'b1, 3'd6, 9'd1, 1'b0, 3'd0);
        do_issue(3'b001, 3'd2, 3'd2, 9'd0, 1'b1, 3'd6, 9'd2, 1'b0, 3'd0);
        checks++;
        if (issue_ready !== 1'b1 || busy_count !== 2'd2) begin
            errors++;
            $display("FAIL t4_two: rdy=%b busy=%0d, required 1 2", issue_ready, busy_count);
        end
        do_issue(3'b101, 3'd3, 3'd3, 9'd0, 1'b1, 3'd6, 9'd3, 1'b0, 3'd0);
        checks++;
        if (issue_ready !== 1'b0 || busy_count !== 2'd3) begin
            errors++;
            $display("FAIL t4_full: rdy=%b busy=%0d, required 0 3", issue_ready, busy_count);
        end
        do_issue(3'b000, 3'd4, 3'd4, 9'd44, 1'b0, 3'd0, 9'd4, 1'b0, 3'd0);
        checks++;
        if (issue_ready !== 1'b0 || busy_count !== 2'd3 || fu_run !== 1'b0) begin
            errors++;
            $display("FAIL t4_ignored: rdy=%b busy=%0d run=%b, required 0 3 0",
                     issue_ready, busy_count, fu_run);
        end
        do_cdb(3'd6, 9'd11);
        wait_dispatch("t4_d0", 1);
        wait_dispatch("t4_d1", 1);
        wait_dispatch("t4_d2", 1);
        checks++;
        if (busy_count !== 2'd0 || issue_ready !== 1'b1) begin
            errors++;
            $display("FAIL t4_drain: busy=%0d rdy=%b, required 0 1", busy_count, issue_ready);
        end
    endtask

    task automatic test_priority;
        exp_t q;
        exp_t r;
        q = mk(3'b001, 3'd5, 3'd6, 9'd100, 9'd50);
        r = mk(3'b000, 3'd7, 3'd7, 9'd200, 9'd60);
        sbq.push_back(mk(3'b000, 3'd0, 3'd1, 9'd1, 9'd1));
        do_issue(3'b000, 3'd0, 3'd1, 9'd1, 1'b0, 3'd0, 9'd1, 1'b0, 3'd0);
        do_issue(q.op, q.addr, q.label, q.x, 1'b0, 3'd0, q.y, 1'b0, 3'd0);
        do_issue(r.op, r.addr, r.label, r.x, 1'b0, 3'd0, r.y, 1'b0, 3'd0);
`ifdef RS_AGE_PRIORITY_EN
        sbq.push_back(q);
        sbq.push_back(r);
`else
        sbq.push_back(r);
        sbq.push_back(q);
`endif
        checks++;
        if (busy_count !== 2'd2 || fu_run !== 1'b1) begin
            errors++;
            $display("FAIL t5_setup: busy=%0d run=%b, required 2 1", busy_count, fu_run);
        end
        wait_dispatch("t5_first_op", 0);
        wait_dispatch("t5_pick_a", 1);
        wait_dispatch("t5_pick_b", 1);
    endtask

    task automatic test_reset_exec;
        do_issue(3'b000, 3'd1, 3'd1, 9'd33, 1'b0, 3'd0, 9'd44, 1'b0, 3'd0);
        do_issue(3'b000, 3'd2, 3'd2, 9'd0, 1'b1, 3'd7, 9'd1, 1'b0, 3'd0);
        do_issue(3'b001, 3'd3, 3'd3, 9'd0, 1'b1, 3'd7, 9'd2, 1'b0, 3'd0);
        checks++;
        if (fu_run !== 1'b1 || busy_count !== 2'd2 || fu_regx !== 9'd33) begin
            errors++;
            $display("FAIL t6_exec: run=%b busy=%0d x=%0d, required 1 2 33",
                     fu_run, busy_count, fu_regx);
        end
        #2 reset = 1'b0;
        #1;
        checks++;
        if (fu_run !== 1'b0 || busy_count !== 2'd0 || issue_ready !== 1'b1 || fu_regx !== 9'd0) begin
            errors++;
            $display("FAIL t6_async: run=%b busy=%0d rdy=%b x=%0d, required 0 0 1 0",
                     fu_run, busy_count, issue_ready, fu_regx);
        end
        @(negedge clk);
        reset = 1'b1;
        do_cdb(3'd7, 9'd77);
        repeat (2) @(negedge clk);
        checks++;
        if (fu_run !== 1'b0 || busy_count !== 2'd0) begin
            errors++;
            $display("FAIL t6_cleared: run=%b busy=%0d, required 0 0", fu_run, busy_count);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0;
        issue_valid = 1'b0; issue_op = '0; issue_addr = '0; issue_label = '0;
        issue_x = '0; issue_x_pend = 1'b0; issue_x_tag = '0;
        issue_y = '0; issue_y_pend = 1'b0; issue_y_tag = '0;
        cdb_valid = 1'b0; cdb_tag = '0; cdb_data = '0;
        fu_done = 1'b0;
        repeat (2) @(negedge clk);
        test_reset;
        reset = 1'b1;
        @(negedge clk);
        test_basic_add;
        test_wakeup;
        test_bypass;
        test_full;
        test_priority;
        test_reset_exec;
        checks++;
        if (sbq.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_empty: %0d left, required 0", sbq.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
